// File: rtl/exp_pkg.sv
// Shared types and default widths for the exponential engine and its batch driver.
package exp_pkg;

  localparam int EXP_XW = 16;
  localparam int EXP_YW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_WAIT
  } drv_state_t;

endpackage

// File: rtl/exp_batch_driver_if.sv
// Sample stream, result stream and engine start/done signals of the batch driver.
interface exp_batch_driver_if
  import exp_pkg::*;
#(
  parameter int XW = EXP_XW,
  parameter int YW = EXP_YW
);

  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic          out_valid;
  logic          out_ready;
  logic [YW-1:0] out_y;
  logic          eng_start;
  logic [XW-1:0] eng_x;
  logic          eng_done;
  logic [YW-1:0] eng_result;

  // master is the driver's view; slave is the source/consumer/engine side
  modport master (
    input  in_valid, in_x, out_ready, eng_done, eng_result,
    output in_ready, out_valid, out_y, eng_start, eng_x
  );

  modport slave (
    output in_valid, in_x, out_ready, eng_done, eng_result,
    input  in_ready, out_valid, out_y, eng_start, eng_x
  );

endinterface

// File: rtl/exp_result_fifo.sv
// Small show-ahead synchronous FIFO holding engine results until the consumer takes them.
module exp_result_fifo
  import exp_pkg::*;
#(
  parameter int WIDTH = EXP_YW,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] entry_data [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a full FIFO can still take a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : entry_data[rd_ptr_reg];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg <= '0;
      end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
        data_reg <= push_data;
      end
    end

    assign entry_data[gi] = data_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/exp_batch_driver.sv
// Feeds x samples to the exp engine one at a time and queues its results for the consumer.
// Optional watchdog on a hung engine: define EXP_DRV_TIMEOUT_EN.
module exp_batch_driver
  import exp_pkg::*;
#(
  parameter int XW             = EXP_XW,
  parameter int YW             = EXP_YW,
  parameter int START_CYCLES   = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  exp_batch_driver_if.master  bus,
  output logic                busy,
  output logic                err_timeout
);

  localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  drv_state_t    state_reg, state_next;
  logic [XW-1:0] x_reg, x_next;
  logic [SCW-1:0] start_cnt_reg, start_cnt_next;
  logic          start_last;
  logic          in_ready_int;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic          timeout_hit;

`ifdef EXP_DRV_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0] to_cnt_reg;
  logic           err_reg;

  // a completion in the final allowed cycle still wins over the timeout
  assign timeout_hit = ((state_reg == S_ARM) || ((state_reg == S_WAIT) && !bus.eng_done)) &&
                       (to_cnt_reg == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if ((state_reg == S_START) && (state_next == S_ARM)) begin
        to_cnt_reg <= '0;
      end else if ((state_reg == S_ARM) || (state_reg == S_WAIT)) begin
        to_cnt_reg <= to_cnt_reg + TCW'(1);
      end
      if (timeout_hit) err_reg <= 1'b1;
    end
  end

  assign err_timeout = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign start_last   = (start_cnt_reg == SCW'(START_CYCLES - 1));
  assign in_ready_int = (state_reg == S_IDLE) & bus.eng_done & ~fifo_full & ~err_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      x_reg         <= '0;
      start_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      start_cnt_reg <= start_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    x_next         = x_reg;
    start_cnt_next = start_cnt_reg;
    push           = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.in_valid && in_ready_int) begin
          x_next         = bus.in_x;
          start_cnt_next = '0;
          state_next     = S_START;
        end
      end
      S_START: begin
        if (start_last) state_next = S_ARM;
        else            start_cnt_next = start_cnt_reg + SCW'(1);
      end
      // done still high here just means the engine has not picked up the start yet
      S_ARM: begin
        if (timeout_hit)        state_next = S_IDLE;
        else if (!bus.eng_done) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_done) begin
          push       = 1'b1;
          state_next = S_IDLE;
        end else if (timeout_hit) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  exp_result_fifo #(
    .WIDTH (YW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.eng_result),
    .pop       (bus.out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (bus.out_y)
  );

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = ~fifo_empty;
  assign bus.eng_start = (state_reg == S_START);
  assign bus.eng_x     = x_reg;
  assign busy          = (state_reg != S_IDLE);

endmodule

// File: doc/exp_batch_driver.md
Name: exp_batch_driver

Overview:
- Initiator side of the exponential engine's start/done handshake: takes x samples from a valid/ready stream, drives eng_start/eng_x per the engine's protocol, waits for eng_done, captures eng_result.
- Results buffered in a small FIFO and presented on a valid/ready output stream.
- Sits between the sample source and the exp engine; one computation in flight at a time.

Parameters:
- XW, 16, width of x sample and eng_x
- YW, 16, width of eng_result and out_y
- START_CYCLES, 2, cycles eng_start held high with eng_x stable (min 1)
- FIFO_DEPTH, 4, result FIFO entries (power of 2, min 2)
- TIMEOUT_CYCLES, 255, cycles allowed in S_ARM+S_WAIT before timeout (feature-gated)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  driver accepts sample this cycle
- in_x  in  XW  input sample
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- out_y  out  YW  FIFO head data
- eng_start  out  1  engine start (high = load x)
- eng_x  out  XW  x presented to engine
- eng_done  in  1  engine idle/done (high in engine Idle)
- eng_result  in  YW  engine result, valid when eng_done high after a run
- busy  out  1  state != S_IDLE
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (sync, rst=1 at posedge): state S_IDLE, FIFO empty, x register 0, counters 0, err_timeout 0. Hence eng_start=0, eng_x=0, out_valid=0, busy=0. Reset mid-run abandons the sample; no FIFO write.
- in_ready = (state==S_IDLE) & eng_done & !fifo_full. Combinational; no dependency on in_valid.
- States and transitions:
  - S_IDLE: on in_valid & in_ready, latch in_x and go to S_START with start counter = 0.
  - S_START: eng_start=1, eng_x = latched x. Lasts exactly START_CYCLES cycles, then S_ARM.
  - S_ARM: eng_start=0. Wait for eng_done==0, which confirms the engine left Idle, then go to S_WAIT.
  - S_WAIT: wait for eng_done==1. In that same cycle, push eng_result into the FIFO and go to S_IDLE.
- eng_x holds the latched value in all non-idle states; it is 0 only after reset.
- FIFO cannot overflow: a start happens only when not full, and only one result is in flight.
- Push is accepted even if the FIFO becomes full that cycle.
- Push and pop in the same cycle: count unchanged, data order preserved.
- Pop when empty: ignored.
- out_y = head entry; undefined-free (0) when empty.
- Latency: accept at cycle c. eng_start is high for cycles c+1 .. c+START_CYCLES. The result is in the FIFO (out_valid) at cycle w+1, where w is the first S_WAIT cycle with eng_done=1.
- eng_done=1 while in S_ARM is not treated as completion; the driver keeps waiting for the low phase.
- Next accept is possible in the cycle after the push, if eng_done=1 and the FIFO is not full.

Optional Feature:
- Macro EXP_DRV_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to S_ARM, incremented each cycle in S_ARM/S_WAIT.
  - When it reaches TIMEOUT_CYCLES: err_timeout set (sticky until rst), sample dropped (no push), go to S_IDLE.
  - While err_timeout=1, in_ready=0.
- Undefined: no counter; err_timeout tied 0; the driver waits indefinitely.

Decomposition:
- Shared package exp_pkg holds:
  - typedef enum logic [1:0] drv_state_t {S_IDLE, S_START, S_ARM, S_WAIT}.
  - Default width constants EXP_XW=16 and EXP_YW=16, also used by the engine datapath.
- Sub-module exp_result_fifo (WIDTH, DEPTH):
  - Sync FIFO with push/pop/full/empty/head.
  - Pointer wrap by DEPTH power of 2; count is log2(DEPTH)+1 bits.

Test Plan:
- BFM engine (done low 9 cycles after start falls, result = x+0x100); in_x=0x0040, out_ready=1 -> eng_start high exactly 2 cycles with eng_x=0x0040; out_y=0x0140 one cycle after eng_done rises.
- out_ready=0, feed 5 samples 1..5 -> 4 results buffered, in_ready=0 with FIFO full. Then out_ready=1 -> outputs 0x101..0x104 in order, 5th sample then processed -> 0x105.
- Hold eng_done=0 at the accept attempt -> in_ready=0 and no start. Release eng_done -> accept next cycle.
- Assert rst for 1 cycle during S_WAIT -> next cycle busy=0, eng_start=0, out_valid=0, no result pushed.
- Simultaneous push and pop with 2 entries -> count stays 2, order intact.
- EXP_DRV_TIMEOUT_EN with TIMEOUT_CYCLES=20, BFM never raises eng_done -> err_timeout=1 after 20 cycles in S_ARM/S_WAIT, FIFO empty, in_ready=0 until rst.
